// File: rtl/fp_alu_sequencer_pkg.sv
// Shared funct/op constants, FSM state encoding and latency-class select
// for the FP ALU issue sequencer.
package fp_alu_sequencer_pkg;

  localparam logic [5:0] FUNADDS  = 6'h00;
  localparam logic [5:0] FUNSUBS  = 6'h01;
  localparam logic [5:0] FUNMULS  = 6'h02;
  localparam logic [5:0] FUNDIVS  = 6'h03;
  localparam logic [5:0] FUNSQRT  = 6'h04;
  localparam logic [5:0] FUNABS   = 6'h05;
  localparam logic [5:0] FUNNEG   = 6'h07;
  localparam logic [5:0] FUNCVTSW = 6'h20;
  localparam logic [5:0] FUNCVTWS = 6'h24;
  localparam logic [5:0] FUNCEQ   = 6'h32;
  localparam logic [5:0] FUNCLT   = 6'h3C;
  localparam logic [5:0] FUNCLE   = 6'h3E;

  localparam logic [3:0] OPNOP    = 4'b0000;
  localparam logic [3:0] OPADDS   = 4'b0001;
  localparam logic [3:0] OPSUBS   = 4'b0010;
  localparam logic [3:0] OPMULS   = 4'b0011;
  localparam logic [3:0] OPDIVS   = 4'b0100;
  localparam logic [3:0] OPSQRT   = 4'b0101;
  localparam logic [3:0] OPABS    = 4'b0110;
  localparam logic [3:0] OPNEG    = 4'b0111;
  localparam logic [3:0] OPCEQ    = 4'b1000;
  localparam logic [3:0] OPCLT    = 4'b1001;
  localparam logic [3:0] OPCLE    = 4'b1010;
  localparam logic [3:0] OPCVTSW  = 4'b1011;
  localparam logic [3:0] OPCVTWS  = 4'b1100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    LAT_ADD  = 3'd0,
    LAT_MUL  = 3'd1,
    LAT_DIV  = 3'd2,
    LAT_SQRT = 3'd3,
    LAT_MISC = 3'd4
  } lat_sel_t;

endpackage

// File: rtl/fp_alu_sequencer_decode.sv
// Combinational funct decode: FPALU op code, legality, compare flag and
// latency class for one FP funct field.
module fp_funct_decode
  import fp_alu_sequencer_pkg::*;
(
  input  logic [5:0] funct,
  output logic [3:0] op,
  output logic       legal,
  output logic       is_compare,
  output logic [2:0] lat_sel
);

  always_comb begin
    op         = OPNOP;
    legal      = 1'b1;
    is_compare = 1'b0;
    lat_sel    = LAT_MISC;
    case (funct)
      FUNADDS:  begin op = OPADDS;  lat_sel = LAT_ADD;  end
      FUNSUBS:  begin op = OPSUBS;  lat_sel = LAT_ADD;  end
      FUNMULS:  begin op = OPMULS;  lat_sel = LAT_MUL;  end
      FUNDIVS:  begin op = OPDIVS;  lat_sel = LAT_DIV;  end
      FUNSQRT:  begin op = OPSQRT;  lat_sel = LAT_SQRT; end
      FUNABS:   op = OPABS;
      FUNNEG:   op = OPNEG;
      FUNCVTSW: op = OPCVTSW;
      FUNCVTWS: op = OPCVTWS;
      FUNCEQ:   begin op = OPCEQ; is_compare = 1'b1; end
      FUNCLT:   begin op = OPCLT; is_compare = 1'b1; end
      FUNCLE:   begin op = OPCLE; is_compare = 1'b1; end
      default:  legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/fp_alu_sequencer.sv
// Multicycle issue sequencer: holds the FPALU op for a per-class latency,
// then pulses completion with the result-register or condition-flag write.
//
// state   | meaning
// IDLE    | no op in flight, op code forced to no-op, start accepted
// EXEC    | op held on oControlSignal, latency counter running
// DONE    | one-cycle completion with write enable; start accepted here too
module fp_alu_sequencer
  import fp_alu_sequencer_pkg::*;
#(
  parameter int ADD_LAT  = 2,
  parameter int MUL_LAT  = 4,
  parameter int DIV_LAT  = 12,
  parameter int SQRT_LAT = 16,
  parameter int MISC_LAT = 1,
  parameter int CNT_W    = 5
) (
  input  logic       iCLK,
  input  logic       iRST,
  input  logic       iStart,
  input  logic [5:0] iFunct,
  input  logic       iAbort,
  output logic [3:0] oControlSignal,
  output logic       oBusy,
  output logic       oDone,
  output logic       oResultWrite,
  output logic       oCondWrite,
  output logic       oIllegal
);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [3:0]         op_q, op_d;
  logic               cmp_q, cmp_d;
  logic               illegal_q, illegal_d;

  logic [3:0]         dec_op;
  logic               dec_legal;
  logic               dec_cmp;
  logic [2:0]         dec_lat_sel;
  logic [CNT_W-1:0]   lat;

  fp_funct_decode u_decode (
    .funct      (iFunct),
    .op         (dec_op),
    .legal      (dec_legal),
    .is_compare (dec_cmp),
    .lat_sel    (dec_lat_sel)
  );

  always_comb begin
    case (dec_lat_sel)
      LAT_ADD:  lat = CNT_W'(ADD_LAT);
      LAT_MUL:  lat = CNT_W'(MUL_LAT);
      LAT_DIV:  lat = CNT_W'(DIV_LAT);
      LAT_SQRT: lat = CNT_W'(SQRT_LAT);
      default:  lat = CNT_W'(MISC_LAT);
    endcase
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      op_q      <= OPNOP;
      cmp_q     <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      cmp_q     <= cmp_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    cmp_d     = cmp_q;
    illegal_d = 1'b0;
    case (state_q)
      ST_EXEC: begin
        // abort takes priority over expiry in the same cycle
        if (iAbort) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          op_d    = OPNOP;
        end else if (cnt_q <= CNT_W'(1)) begin
          state_d = ST_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        op_d    = OPNOP;
        cmp_d   = 1'b0;
        if (iStart) begin
          if (dec_legal) begin
            state_d = ST_EXEC;
            cnt_d   = lat;
            op_d    = dec_op;
            cmp_d   = dec_cmp;
          end else begin
            illegal_d = 1'b1;
          end
        end
      end
    endcase
  end

  assign oBusy          = (state_q == ST_EXEC);
  assign oDone          = (state_q == ST_DONE);
  assign oControlSignal = (state_q == ST_IDLE) ? OPNOP : op_q;
  assign oResultWrite   = oDone & ~cmp_q;
  assign oCondWrite     = oDone & cmp_q;
  assign oIllegal       = illegal_q;

endmodule

// File: tb/tb_fp_alu_sequencer.sv
// Scoreboard bench for fp_alu_sequencer: directed scenarios followed by
// random start/abort/reset traffic against a cycle-indexed reference model.
module tb_fp_alu_sequencer;

  localparam int MAXC = 8192;

  logic       clk;
  logic       iRST, iStart, iAbort;
  logic [5:0] iFunct;
  logic [3:0] oControlSignal;
  logic       oBusy, oDone, oResultWrite, oCondWrite, oIllegal;

  fp_alu_sequencer dut (
    .iCLK          (clk),
    .iRST          (iRST),
    .iStart        (iStart),
    .iFunct        (iFunct),
    .iAbort        (iAbort),
    .oControlSignal(oControlSignal),
    .oBusy         (oBusy),
    .oDone         (oDone),
    .oResultWrite  (oResultWrite),
    .oCondWrite    (oCondWrite),
    .oIllegal      (oIllegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    bit         ill;
    logic [3:0] op;
    bit         cmp;
  } exp_t;

  exp_t       q[$];
  logic       exp_busy [MAXC];
  logic [3:0] exp_ctrl [MAXC];
  int         checks = 0;
  int         failures = 0;
  bit         mon_en = 0;
  int         bs = 0;
  int         be = -1;

  // Reference table: funct, op code, execute cycles (default parameters), compare
  logic [5:0] t_funct [12] = '{6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h05,
                               6'h07, 6'h32, 6'h3C, 6'h3E, 6'h20, 6'h24};
  logic [3:0] t_op    [12] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6,
                               4'd7, 4'd8, 4'd9, 4'd10, 4'd11, 4'd12};
  int         t_lat   [12] = '{2, 2, 4, 12, 16, 1, 1, 1, 1, 1, 1, 1};
  bit         t_cmp   [12] = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0};

  task automatic ref_lookup(input logic [5:0] f, output bit lg,
                            output logic [3:0] op, output int lat, output bit cm);
    lg = 0; op = 4'd0; lat = 0; cm = 0;
    for (int i = 0; i < 12; i++)
      if (t_funct[i] == f) begin
        lg = 1; op = t_op[i]; lat = t_lat[i]; cm = t_cmp[i];
      end
  endtask

  task automatic purge(input int d);
    while (q.size() > 0 && q[$].cyc > d) void'(q.pop_back());
    for (int c = d + 1; c < d + 24 && c < MAXC; c++) begin
      exp_busy[c] = 1'b0;
      exp_ctrl[c] = 4'd0;
    end
  endtask

  // Drive one cycle of inputs and advance the model; inputs driven in cycle d
  // are seen by the DUT at the edge that starts cycle d+1.
  task automatic step(input logic r, input logic s, input logic [5:0] f, input logic a);
    int d;
    bit lg, cm;
    logic [3:0] op;
    int lat;
    exp_t e;
    d = cyc;
    iRST = r; iStart = s; iFunct = f; iAbort = a;
    if (r) begin
      purge(d); bs = 0; be = -1;
    end else if (d >= bs && d <= be) begin
      if (a) begin
        purge(d); bs = 0; be = -1;
      end
    end else if (s) begin
      ref_lookup(f, lg, op, lat, cm);
      if (lg) begin
        e.cyc = d + lat + 1; e.ill = 0; e.op = op; e.cmp = cm;
        q.push_back(e);
        for (int c = d + 1; c <= d + lat + 1 && c < MAXC; c++) begin
          exp_busy[c] = (c <= d + lat);
          exp_ctrl[c] = op;
        end
        bs = d + 1; be = d + lat;
      end else begin
        e.cyc = d + 1; e.ill = 1; e.op = 4'd0; e.cmp = 0;
        q.push_back(e);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 6'h00, 1'b0);
  endtask

  always @(negedge clk) begin
    int c;
    exp_t e;
    if (mon_en) begin
      c = cyc;
      checks++;
      if (oBusy !== exp_busy[c]) begin
        failures++;
        $display("FAIL busy cyc=%0d got=%b exp=%b", c, oBusy, exp_busy[c]);
      end
      checks++;
      if (oControlSignal !== exp_ctrl[c]) begin
        failures++;
        $display("FAIL ctrl cyc=%0d got=%0d exp=%0d", c, oControlSignal, exp_ctrl[c]);
      end
      if (oDone === 1'b1 || oIllegal === 1'b1) begin
        checks++;
        if (q.size() == 0 || q[0].cyc != c) begin
          failures++;
          $display("FAIL unexpected_event cyc=%0d done=%b illegal=%b", c, oDone, oIllegal);
        end else begin
          e = q.pop_front();
          if (oDone !== !e.ill || oIllegal !== e.ill ||
              (!e.ill && (oResultWrite !== !e.cmp || oCondWrite !== e.cmp))) begin
            failures++;
            $display("FAIL event cyc=%0d got done=%b ill=%b rw=%b cw=%b exp ill=%b cmp=%b",
                     c, oDone, oIllegal, oResultWrite, oCondWrite, e.ill, e.cmp);
          end
        end
      end else begin
        checks++;
        if (oResultWrite !== 1'b0 || oCondWrite !== 1'b0 || oDone !== 1'b0 || oIllegal !== 1'b0) begin
          failures++;
          $display("FAIL quiet_outputs cyc=%0d done=%b ill=%b rw=%b cw=%b exp all 0",
                   c, oDone, oIllegal, oResultWrite, oCondWrite);
        end
        if (q.size() > 0 && q[0].cyc == c) begin
          e = q.pop_front();
          failures++;
          $display("FAIL missing_event cyc=%0d got done=0 illegal=0 exp ill=%b", c, e.ill);
        end
      end
    end
  end

  initial begin
    logic [5:0] f;
    for (int i = 0; i < MAXC; i++) begin
      exp_busy[i] = 1'b0;
      exp_ctrl[i] = 4'd0;
    end
    iRST = 1'b1; iStart = 1'b0; iFunct = 6'h00; iAbort = 1'b0;
    @(posedge clk); #1;
    mon_en = 1;
    step(1'b1, 1'b0, 6'h00, 1'b0);
    idle(2);

    // reset in EXEC cycle 5 of a divide
    step(1'b0, 1'b1, 6'h03, 1'b0);
    idle(4);
    step(1'b1, 1'b0, 6'h00, 1'b0);
    idle(20);
    // add, compare-less-than, illegal funct
    step(1'b0, 1'b1, 6'h00, 1'b0);
    idle(5);
    step(1'b0, 1'b1, 6'h3C, 1'b0);
    idle(4);
    step(1'b0, 1'b1, 6'h3F, 1'b0);
    idle(3);
    // sqrt with ignored mul in cycle 8, accepted mul in the DONE cycle
    step(1'b0, 1'b1, 6'h04, 1'b0);
    idle(7);
    step(1'b0, 1'b1, 6'h02, 1'b0);
    idle(8);
    step(1'b0, 1'b1, 6'h02, 1'b0);
    idle(8);
    // divide with abort coinciding with expiry
    step(1'b0, 1'b1, 6'h03, 1'b0);
    idle(11);
    step(1'b0, 1'b0, 6'h00, 1'b1);
    idle(5);

    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(1) == 0) f = t_funct[$urandom_range(11)];
      else f = 6'($urandom);
      step(($urandom_range(299) == 0), ($urandom_range(2) == 0), f,
           ($urandom_range(19) == 0));
    end
    idle(40);

    mon_en = 0;
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL leftover_events got=%0d exp=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
